paddle_mover: RTL and testbench



---
 rtl/paddle_pkg.sv | 18 +
 rtl/paddle_mover_pending_ctr.sv | 44 ++++
 rtl/paddle_mover.sv | 128 ++++++++++++
 tb/tb_paddle_mover.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// paddle_pkg: shared paddle FSM states and default geometry.
// Reused by the renderer and the collision logic.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        UPDATE
    } state_e;

    localparam int POS_W_DEF    = 10;
    localparam int POS_MIN_DEF  = 0;
    localparam int POS_MAX_DEF  = 440;
    localparam int POS_INIT_DEF = 220;
    localparam int STEP_DEF     = 16;
    localparam int PEND_W_DEF   = 3;

endpackage

// File: rtl/paddle_mover_pending_ctr.sv
// pending_ctr: saturating signed up/down counter of queued moves.
// consume_dir_i[0] takes one positive request, [1] one negative.
module pending_ctr
    import paddle_pkg::*;
#(
    parameter int W = PEND_W_DEF
) (
    input  logic                vgaclk,
    input  logic                reset,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic [1:0]          consume_dir_i,
    input  logic                clear_i,
    output logic signed [W-1:0] count_o,
    output logic signed [W-1:0] next_o
);
    localparam int LIM = 2 ** (W - 1) - 1;

    logic signed [W-1:0] count_q;
    logic signed [W-1:0] count_d;
    int                  sum;

    always_comb begin
        sum = int'(count_q) + int'(inc_i) - int'(dec_i);
        if (consume_dir_i[0]) sum = sum - 1;
        if (consume_dir_i[1]) sum = sum + 1;
        if (sum > LIM) sum = LIM;
        if (sum < -LIM) sum = -LIM;
        // a clamped step drops the backlog but keeps a fresh opposite pulse
        if (clear_i) begin
            sum = consume_dir_i[0] ? -int'(dec_i) : int'(inc_i);
        end
        count_d = W'(sum);
    end

    always_ff @(posedge vgaclk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/paddle_mover.sv
// paddle_mover: applies queued left/right moves once per frame tick.
// Define PADDLE_WRAP_EN to wrap at the bounds instead of saturating.
module paddle_mover
    import paddle_pkg::*;
#(
    parameter int POS_W    = POS_W_DEF,
    parameter int POS_MIN  = POS_MIN_DEF,
    parameter int POS_MAX  = POS_MAX_DEF,
    parameter int POS_INIT = POS_INIT_DEF,
    parameter int STEP     = STEP_DEF,
    parameter int PEND_W   = PEND_W_DEF
) (
    input  logic             vgaclk,
    input  logic             reset,
    input  logic             left_pulse,
    input  logic             right_pulse,
    input  logic             frame_tick,
    output logic [POS_W-1:0] pos,
    output logic             moving,
    output logic             at_min,
    output logic             at_max
);
    localparam logic [POS_W:0] MIN_X  = (POS_W + 1)'(POS_MIN);
    localparam logic [POS_W:0] MAX_X  = (POS_W + 1)'(POS_MAX);
    localparam logic [POS_W:0] STEP_X = (POS_W + 1)'(STEP);
    localparam logic [POS_W:0] SPAN_X = (POS_W + 1)'(POS_MAX - POS_MIN + 1);

    state_e             state_q;
    logic [POS_W-1:0]   pos_q;
    logic               moving_q;
    logic               at_min_q;
    logic               at_max_q;

    logic signed [PEND_W-1:0] pend_q;
    logic signed [PEND_W-1:0] pend_next;
    logic                     pend_nz;
    logic                     go_up;
    logic                     go_dn;
    logic                     clamp;
    logic [POS_W:0]           up_sum;
    logic [POS_W:0]           target_d;

    assign go_up   = (state_q == UPDATE) && !pend_q[PEND_W-1]
                     && (pend_q != '0);
    assign go_dn   = (state_q == UPDATE) && pend_q[PEND_W-1];
    assign pend_nz = (pend_next != '0);

    pending_ctr #(
        .W(PEND_W)
    ) u_pend (
        .vgaclk       (vgaclk),
        .reset        (reset),
        .inc_i        (right_pulse),
        .dec_i        (left_pulse),
        .consume_dir_i({go_dn, go_up}),
        .clear_i      (clamp),
        .count_o      (pend_q),
        .next_o       (pend_next)
    );

    always_comb begin
        up_sum   = {1'b0, pos_q} + STEP_X;
        target_d = {1'b0, pos_q};
        clamp    = 1'b0;
        if (go_up) begin
            if (up_sum > MAX_X) begin
`ifdef PADDLE_WRAP_EN
                target_d = up_sum - SPAN_X;
`else
                target_d = MAX_X;
                clamp    = 1'b1;
`endif
            end else begin
                target_d = up_sum;
            end
        end else if (go_dn) begin
            // compare before subtracting so the left step never underflows
            if ({1'b0, pos_q} < MIN_X + STEP_X) begin
`ifdef PADDLE_WRAP_EN
                target_d = {1'b0, pos_q} + SPAN_X - STEP_X;
`else
                target_d = MIN_X;
                clamp    = 1'b1;
`endif
            end else begin
                target_d = {1'b0, pos_q} - STEP_X;
            end
        end
    end

    always_ff @(posedge vgaclk) begin
        if (reset) begin
            state_q  <= IDLE;
            pos_q    <= POS_W'(POS_INIT);
            moving_q <= 1'b0;
            at_min_q <= (POS_INIT == POS_MIN);
            at_max_q <= (POS_INIT == POS_MAX);
        end else begin
            moving_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pend_nz) state_q <= ARMED;
                end
                ARMED: begin
                    if (!pend_nz) begin
                        state_q <= IDLE;
                    end else if (frame_tick) begin
                        state_q  <= UPDATE;
                        moving_q <= 1'b1;
                    end
                end
                UPDATE: begin
                    pos_q    <= target_d[POS_W-1:0];
                    at_min_q <= (target_d == MIN_X);
                    at_max_q <= (target_d == MAX_X);
                    state_q  <= pend_nz ? ARMED : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pos    = pos_q;
    assign moving = moving_q;
    assign at_min = at_min_q;
    assign at_max = at_max_q;

endmodule

// File: tb/tb_paddle_mover.sv
// tb_paddle_mover: directed stimulus, per-cycle model compare and
// hand-computed checkpoints for paddle_mover.
module tb_paddle_mover;
    localparam int MIN  = 0;
    localparam int MAX  = 440;
    localparam int INIT = 220;
    localparam int STEP = 16;
    localparam int LIM  = 3;

    logic       vgaclk = 1'b0;
    logic       reset = 1'b1;
    logic       left_pulse = 1'b0;
    logic       right_pulse = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] pos;
    logic       moving;
    logic       at_min;
    logic       at_max;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // model: position, backlog, "waiting for a tick", "stepping now"
    int m_pos, m_pend, n_pos, n_pend;
    bit m_wait, m_step, n_wait, n_step;
    int cons;
    bit clr;

    paddle_mover dut (
        .vgaclk     (vgaclk),
        .reset      (reset),
        .left_pulse (left_pulse),
        .right_pulse(right_pulse),
        .frame_tick (frame_tick),
        .pos        (pos),
        .moving     (moving),
        .at_min     (at_min),
        .at_max     (at_max)
    );

    always #5 vgaclk = ~vgaclk;

    always @* begin
        cons   = 0;
        clr    = 1'b0;
        n_pos  = m_pos;
        if (m_step) cons = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
`ifdef PADDLE_WRAP_EN
        if (cons > 0)
            n_pos = (m_pos + STEP > MAX) ? m_pos + STEP - (MAX - MIN + 1)
                                         : m_pos + STEP;
        if (cons < 0)
            n_pos = (m_pos - STEP < MIN) ? m_pos - STEP + (MAX - MIN + 1)
                                         : m_pos - STEP;
`else
        if (cons > 0) n_pos = (m_pos + STEP > MAX) ? MAX : m_pos + STEP;
        if (cons < 0) n_pos = (m_pos - STEP < MIN) ? MIN : m_pos - STEP;
        clr = (cons > 0 && m_pos + STEP > MAX) ||
              (cons < 0 && m_pos - STEP < MIN);
`endif
        n_pend = m_pend + int'(right_pulse) - int'(left_pulse) - cons;
        if (n_pend > LIM) n_pend = LIM;
        if (n_pend < -LIM) n_pend = -LIM;
        if (clr) n_pend = (cons > 0) ? -int'(left_pulse) : int'(right_pulse);
        n_step = m_wait && frame_tick && (n_pend != 0);
        n_wait = (n_pend != 0) && !n_step;
    end

    always @(posedge vgaclk) begin
        if (reset) begin
            m_pos  <= INIT;
            m_pend <= 0;
            m_wait <= 1'b0;
            m_step <= 1'b0;
        end else begin
            m_pos  <= n_pos;
            m_pend <= n_pend;
            m_wait <= n_wait;
            m_step <= n_step;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge vgaclk) begin
        if (chk_en) begin
            chk("cyc_pos", int'(pos), m_pos);
            chk("cyc_moving", int'(moving), int'(m_step));
            chk("cyc_at_min", int'(at_min), int'(m_pos == MIN));
            chk("cyc_at_max", int'(at_max), int'(m_pos == MAX));
            chk("cyc_pending", int'(dut.u_pend.count_o), m_pend);
        end
    end

    task automatic cyc();
        @(negedge vgaclk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
    endtask

    task automatic step(input bit right);
        if (right) right_pulse = 1'b1;
        else       left_pulse = 1'b1;
        cyc();
        right_pulse = 1'b0;
        left_pulse  = 1'b0;
        tick();
        cyc();
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_pos [4];
        exp_pos = '{236, 252, 268, 268};

        do_reset();
        chk_en = 1'b1;
        chk("rst_pos", int'(pos), 220);
        chk("rst_at_min", int'(at_min), 0);
        chk("rst_at_max", int'(at_max), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_pending", int'(dut.u_pend.count_o), 0);

        right_pulse = 1'b1;
        cyc();
        right_pulse = 1'b0;
        cyc();
        cyc();
        tick();
        chk("t1_moving", int'(moving), 1);
        chk("t1_pos_hold", int'(pos), 220);
        cyc();
        chk("t1_pos", int'(pos), 236);
        chk("t1_moving_low", int'(moving), 0);
        cyc();
        chk("t1_pending", int'(dut.u_pend.count_o), 0);

        do_reset();
        right_pulse = 1'b1;
        repeat (5) cyc();
        right_pulse = 1'b0;
        cyc();
        chk("t2_sat", int'(dut.u_pend.count_o), 3);
        for (int i = 0; i < 4; i++) begin
            tick();
            cyc();
            chk("t2_pos", int'(pos), exp_pos[i]);
            cyc();
        end

        do_reset();
`ifdef PADDLE_WRAP_EN
        for (int i = 0; i < 500 && m_pos != 432; i++) step(1'b1);
        chk("t3_nav", int'(pos), 432);
        step(1'b1);
        chk("t3_wrap", int'(pos), 7);
`else
        for (int i = 0; i < 20 && m_pos != 0; i++) step(1'b0);
        chk("t3_min", int'(pos), 0);
        chk("t3_at_min", int'(at_min), 1);
        for (int i = 0; i < 40 && m_pos != 432; i++) step(1'b1);
        chk("t3_nav", int'(pos), 432);
        right_pulse = 1'b1;
        repeat (3) cyc();
        right_pulse = 1'b0;
        tick();
        cyc();
        chk("t3_clamp", int'(pos), 440);
        chk("t3_at_max", int'(at_max), 1);
        cyc();
        chk("t3_cleared", int'(dut.u_pend.count_o), 0);
        tick();
        cyc();
        step(1'b1);
        chk("t3_hold", int'(pos), 440);
        chk("t3_pend0", int'(dut.u_pend.count_o), 0);
`endif

        do_reset();
        left_pulse  = 1'b1;
        right_pulse = 1'b1;
        cyc();
        left_pulse  = 1'b0;
        right_pulse = 1'b0;
        cyc();
        chk("t4_cancel", int'(dut.u_pend.count_o), 0);
        tick();
        cyc();
        right_pulse = 1'b1;
        cyc();
        right_pulse = 1'b0;
        left_pulse  = 1'b1;
        cyc();
        left_pulse = 1'b0;
        tick();
        cyc();
        chk("t4_pos", int'(pos), 220);
        chk("t4_pend", int'(dut.u_pend.count_o), 0);

        do_reset();
        right_pulse = 1'b1;
        frame_tick  = 1'b1;
        cyc();
        right_pulse = 1'b0;
        frame_tick  = 1'b0;
        cyc();
        cyc();
        chk("t5_wait", int'(pos), 220);
        tick();
        cyc();
        chk("t5_pos", int'(pos), 236);

        do_reset();
        right_pulse = 1'b1;
        cyc();
        right_pulse = 1'b0;
        tick();
        chk("t6_in_update", int'(moving), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_pos", int'(pos), 220);
        chk("t6_moving", int'(moving), 0);
        chk("t6_pend", int'(dut.u_pend.count_o), 0);
        tick();
        cyc();
        chk("t6_idle", int'(pos), 220);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
